// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg : parameterised UART transmitter with a small transmit FIFO.
//
// Words written with i_Tx_DV are queued in a FIFO_DEPTH-entry FIFO. The
// frame engine pops one word whenever it is idle. It then serialises the
// frame: start bit, DATA_BITS data bits LSB first, an optional parity bit,
// and STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clock cycles.
//
// Ports
//   i_Clock      : sole clock, rising edge
//   i_Reset      : synchronous active-high reset
//   i_Tx_DV      : write strobe, accepted only while o_Tx_Ready is high
//   i_Tx_Byte    : data word to queue (DATA_BITS wide)
//   o_Tx_Ready   : FIFO not full
//   o_Tx_Serial  : registered serial line, idle high
//   o_Tx_Active  : high from the start-bit edge to the end of the last stop bit
//   o_Tx_Done    : one-cycle pulse per completed frame
//   o_Fifo_Count : number of queued words not yet popped
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
   parameter int CLKS_PER_BIT = 437,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,   // 0 none, 1 odd, 2 even
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  logic                          i_Tx_DV,
   input  logic [DATA_BITS-1:0]          i_Tx_Byte,
   output logic                          o_Tx_Ready,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Done,
   output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
   localparam int IDX_W = $clog2(DATA_BITS);

   // Reject illegal configurations at elaboration.
   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, >= 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   // ---------------- transmit FIFO ----------------
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       count_q,  count_d;
   logic                 push, pop;

   state_t               state_q;

   // Ready looks only at the count, so a pop in the same cycle cannot
   // make a full FIFO accept a write.
   assign o_Tx_Ready   = (count_q < (PTR_W + 1)'(FIFO_DEPTH));
   assign o_Fifo_Count = count_q;
   assign push         = i_Tx_DV & o_Tx_Ready;
   assign pop          = (state_q == IDLE) && (count_q != '0);

   // NOTE: every variable written in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;   // power-of-2 depth: wraps for free
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; emptying the FIFO only needs the pointers and count cleared.
   always_ff @(posedge i_Clock) begin
      if (!i_Reset && push) mem_q[wr_ptr_q] <= i_Tx_Byte;
   end

   // ---------------- frame engine ----------------
   logic [DATA_BITS-1:0] data_q;     // shift register holding the word in flight
   logic                 parity_q;
   logic [CNT_W-1:0]     clk_cnt_q;
   logic [IDX_W-1:0]     bit_idx_q;
   logic                 serial_q, active_q, done_q;

   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= IDLE;
         serial_q  <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         data_q    <= '0;
         parity_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               clk_cnt_q <= '0;
               bit_idx_q <= '0;
               if (pop) begin
                  data_q   <= mem_q[rd_ptr_q];
                  // Even parity is the plain XOR; odd parity inverts it.
                  parity_q <= (^mem_q[rd_ptr_q]) ^ (PARITY_MODE == 1);
                  serial_q <= 1'b0;
                  active_q <= 1'b1;
                  state_q  <= START;
               end
            end
            START: begin
               if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                  clk_cnt_q <= '0;
                  serial_q  <= data_q[0];
                  state_q   <= DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                  clk_cnt_q <= '0;
                  if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                     bit_idx_q <= '0;
                     if (PARITY_MODE != 0) begin
                        serial_q <= parity_q;
                        state_q  <= PARITY;
                     end else begin
                        serial_q <= 1'b1;
                        state_q  <= STOP;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                     serial_q  <= data_q[1];
                     data_q    <= data_q >> 1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end
            PARITY: begin
               if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                  clk_cnt_q <= '0;
                  serial_q  <= 1'b1;
                  state_q   <= STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end
            STOP: begin
               // All stop bits are timed as one continuous high interval.
               if (clk_cnt_q == CNT_W'(STOP_BITS * CLKS_PER_BIT - 1)) begin
                  clk_cnt_q <= '0;
                  done_q    <= 1'b1;
                  active_q  <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg : directed self-checking bench for uart_tx_cfg.
// Four instances cover the configurations of interest:
//   a : CPB=4, 8 data bits, even parity, 1 stop, depth 4
//   b : CPB=4, 7 data bits, odd parity,  1 stop
//   c : CPB=4, 7 data bits, even parity, 1 stop
//   d : CPB=2, 5 data bits, no parity,   2 stop
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_o;
   logic       dv_a, dv_b, dv_c, dv_d;
   logic [7:0] byte_a;
   logic [6:0] byte_b, byte_c;
   logic [4:0] byte_d;
   logic       rdy_a, rdy_b, rdy_c, rdy_d;
   logic       ser_a, ser_b, ser_c, ser_d;
   logic       act_a, act_b, act_c, act_d;
   logic       dn_a, dn_b, dn_c, dn_d;
   logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;

   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
      .i_Clock(clk), .i_Reset(rst_a), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
      .o_Tx_Ready(rdy_a), .o_Tx_Serial(ser_a), .o_Tx_Active(act_a), .o_Tx_Done(dn_a),
      .o_Fifo_Count(cnt_a));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
      .i_Clock(clk), .i_Reset(rst_o), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
      .o_Tx_Ready(rdy_b), .o_Tx_Serial(ser_b), .o_Tx_Active(act_b), .o_Tx_Done(dn_b),
      .o_Fifo_Count(cnt_b));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
      .i_Clock(clk), .i_Reset(rst_o), .i_Tx_DV(dv_c), .i_Tx_Byte(byte_c),
      .o_Tx_Ready(rdy_c), .o_Tx_Serial(ser_c), .o_Tx_Active(act_c), .o_Tx_Done(dn_c),
      .o_Fifo_Count(cnt_c));
   uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
      .i_Clock(clk), .i_Reset(rst_o), .i_Tx_DV(dv_d), .i_Tx_Byte(byte_d),
      .o_Tx_Ready(rdy_d), .o_Tx_Serial(ser_d), .o_Tx_Active(act_d), .o_Tx_Done(dn_d),
      .o_Fifo_Count(cnt_d));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ser(input int w);
      case (w)
         0:       return ser_a;
         1:       return ser_b;
         2:       return ser_c;
         default: return ser_d;
      endcase
   endfunction

   function automatic logic act(input int w);
      case (w)
         0:       return act_a;
         1:       return act_b;
         2:       return act_c;
         default: return act_d;
      endcase
   endfunction

   function automatic logic dn(input int w);
      case (w)
         0:       return dn_a;
         1:       return dn_b;
         2:       return dn_c;
         default: return dn_d;
      endcase
   endfunction

   task automatic drive(input int w, input logic v, input logic [8:0] d);
      case (w)
         0:       begin dv_a = v; byte_a = d[7:0]; end
         1:       begin dv_b = v; byte_b = d[6:0]; end
         2:       begin dv_c = v; byte_c = d[6:0]; end
         default: begin dv_d = v; byte_d = d[4:0]; end
      endcase
   endtask

   // Write one word into an idle, empty instance and check the whole frame.
   // fr holds the expected line value per bit time, bit 0 = start bit.
   task automatic write_and_frame(input int w, input logic [8:0] d, input int cpb,
                                  input logic [15:0] fr, input int nbits, input string tag);
      drive(w, 1'b1, d);
      tick();                       // push edge
      drive(w, 1'b0, d);
      tick();                       // pop edge: start bit begins
      for (int p = 0; p < nbits * cpb; p++) begin
         check($sformatf("%s serial cyc%0d", tag, p), 32'(ser(w)), 32'(fr[p / cpb]));
         check($sformatf("%s active cyc%0d", tag, p), 32'(act(w)), 32'd1);
         check($sformatf("%s done cyc%0d", tag, p), 32'(dn(w)), 32'd0);
         tick();
      end
      check({tag, " done pulse"}, 32'(dn(w)), 32'd1);
      check({tag, " active end"}, 32'(act(w)), 32'd0);
      check({tag, " idle line"},  32'(ser(w)), 32'd1);
      tick();
      check({tag, " done single"}, 32'(dn(w)), 32'd0);
   endtask

   // Expected line value for instance a: bit time b of the frame of 'word'.
   function automatic logic fa_bit(input logic [7:0] word, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return word[b - 1];
      if (b == 9) return ^word;     // even parity
      return 1'b1;
   endfunction

   logic [7:0] words [6];

   initial begin
      rst_a = 1'b1; rst_o = 1'b1;
      dv_a = 1'b1; byte_a = 8'hEE;  // strobe during reset must be ignored
      dv_b = 1'b0; byte_b = '0;
      dv_c = 1'b0; byte_c = '0;
      dv_d = 1'b0; byte_d = '0;
      tick();
      tick();
      check("reset serial", 32'(ser_a), 32'd1);
      check("reset active", 32'(act_a), 32'd0);
      check("reset done",   32'(dn_a),  32'd0);
      check("reset count",  32'(cnt_a), 32'd0);
      check("reset ready",  32'(rdy_a), 32'd1);
      check("reset count d", 32'(cnt_d), 32'd0);
      dv_a = 1'b0;
      rst_a = 1'b0; rst_o = 1'b0;
      tick();
      check("post-reset count", 32'(cnt_a), 32'd0);
      check("post-reset line",  32'(ser_a), 32'd1);

      // 0xA5, 8E1: 0,1,0,1,0,0,1,0,1,parity 0,stop 1 -> 44 cycles
      write_and_frame(0, 9'h0A5, 4, 16'h054A, 11, "a5_even");
      // 0x07, 7O1: parity 0
      write_and_frame(1, 9'h007, 4, 16'h020E, 10, "07_odd");
      // 0x07, 7E1: parity 1
      write_and_frame(2, 9'h007, 4, 16'h030E, 10, "07_even");
      // 0x1F, 5N2, CPB 2: 8 bit times, 16 cycles
      write_and_frame(3, 9'h01F, 2, 16'h00FE, 8, "1f_5n2");

      // Six writes on consecutive cycles, then hold the 6th while full.
      // Edge n: first write at n=0, pops at n = 1 + 45*f, done at 45 + 45*f.
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h3C;
      words[3] = 8'h81; words[4] = 8'h5A; words[5] = 8'hF0;
      begin
         int cnt_m;
         cnt_m = 0;
         for (int n = 0; n <= 1 + 45 * 6 + 1; n++) begin
            logic   dv_n, push_m, pop_m, exp_ser, exp_dn;
            int     f, p;
            dv_n = (n <= 47);
            dv_a = dv_n;
            byte_a = (n < 5) ? words[n] : words[5];
            push_m = dv_n && (cnt_m < 4);
            pop_m  = (n >= 1) && ((n - 1) % 45 == 0) && ((n - 1) / 45 < 6);
            cnt_m  = cnt_m + int'(push_m) - int'(pop_m);
            tick();
            f = (n >= 1) ? (n - 1) / 45 : 6;
            p = (n >= 1) ? (n - 1) % 45 : 44;
            exp_ser = (f < 6 && p < 44) ? fa_bit(words[f], p / 4) : 1'b1;
            exp_dn  = (f < 6 && p == 44);
            check($sformatf("burst serial e%0d", n), 32'(ser_a), 32'(exp_ser));
            check($sformatf("burst done e%0d", n),   32'(dn_a),  32'(exp_dn));
            check($sformatf("burst count e%0d", n),  32'(cnt_a), 32'(cnt_m));
            check($sformatf("burst ready e%0d", n),  32'(rdy_a), 32'(cnt_m < 4));
         end
         dv_a = 1'b0;
         check("burst final count", 32'(cnt_a), 32'd0);
      end

      // Reset in the middle of the DATA phase with two words queued.
      tick();
      dv_a = 1'b1; byte_a = 8'h11;
      tick();                          // e0: push
      byte_a = 8'h22;
      tick();                          // e1: pop + push
      byte_a = 8'h33;
      tick();                          // e2: push
      dv_a = 1'b0;
      for (int i = 3; i <= 9; i++) tick();
      check("pre-abort count",  32'(cnt_a), 32'd2);
      check("pre-abort active", 32'(act_a), 32'd1);
      rst_a = 1'b1;
      tick();                          // e10: reset edge
      rst_a = 1'b0;
      check("abort serial", 32'(ser_a), 32'd1);
      check("abort active", 32'(act_a), 32'd0);
      check("abort count",  32'(cnt_a), 32'd0);
      check("abort ready",  32'(rdy_a), 32'd1);
      check("abort done",   32'(dn_a),  32'd0);
      for (int i = 0; i < 60; i++) begin
         tick();
         check($sformatf("abort quiet done %0d", i), 32'(dn_a),  32'd0);
         check($sformatf("abort quiet line %0d", i), 32'(ser_a), 32'd1);
      end
      // 0x3C, 8E1: parity 0
      write_and_frame(0, 9'h03C, 4, 16'h0478, 11, "3c_after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
